// File: rtl/matrix_scan_controller.sv
// matrix_scan_controller
// Walks an LED-matrix frame column by column, fetching one packed
// multi-channel SPI word per step from the frame buffer and handing it to
// output_module together with the matching command pulse. The next word is
// prefetched while output_module is still busy with the current one.
//
// Optional feature: define MATRIX_SCAN_AUTO_REPEAT_EN to make the controller
// rescan frames continuously after a single frame_start.
module matrix_scan_controller #(
    parameter int CHANNEL_NUMBER   = 3,
    parameter int SPI_SIZE         = 8,
    parameter int COLUMNS          = 16,
    parameter int WORDS_PER_COLUMN = 8,
    parameter int PULSE_LEN        = 1,
    parameter int ADDR_WIDTH       = $clog2(COLUMNS*WORDS_PER_COLUMN)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               frame_start,
    output logic                               busy,
    output logic                               frame_done,
    output logic                               rd_en,
    output logic [ADDR_WIDTH-1:0]              rd_addr,
    input  logic [CHANNEL_NUMBER*SPI_SIZE-1:0] rd_data,
    output logic [CHANNEL_NUMBER*SPI_SIZE-1:0] data_out,
    output logic                               extra_bit,
    output logic                               new_image,
    output logic                               new_column,
    output logic                               next_data,
    input  logic                               tx_finish
);

    localparam int DATA_W = CHANNEL_NUMBER * SPI_SIZE;
    localparam int COL_W  = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam int WORD_W = (WORDS_PER_COLUMN > 1) ? $clog2(WORDS_PER_COLUMN) : 1;

    // Prefetch phases inside WAIT_ACK: strobe the read, capture it, then idle.
    localparam logic [1:0] PF_ISSUE   = 2'd0;
    localparam logic [1:0] PF_CAPTURE = 2'd1;
    localparam logic [1:0] PF_DONE    = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT_READY,
        S_PULSE,
        S_WAIT_ACK,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [3:0]          pcnt_q, pcnt_d;
    logic [1:0]          pf_q, pf_d;
    logic                ack_seen_q, ack_seen_d;
    logic                pending_q, pending_d;
    logic [DATA_W-1:0]   stage_q, stage_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                extra_q, extra_d;

    logic word_last;
    logic frame_last;
    logic pulse_last;
    logic restart;
    logic start_frame;

    assign word_last  = (word_q == WORD_W'(WORDS_PER_COLUMN - 1));
    assign frame_last = word_last && (col_q == COL_W'(COLUMNS - 1));
    assign pulse_last = (pcnt_q == 4'(PULSE_LEN - 1));

`ifdef MATRIX_SCAN_AUTO_REPEAT_EN
    // Continuous scanning: every completed frame immediately starts the next.
    assign restart = 1'b1;
`else
    // A request that arrived during the frame (or right at its end) restarts it.
    assign restart = pending_q || frame_start;
`endif

    assign start_frame = ((state_q == S_IDLE) && frame_start) ||
                         ((state_q == S_DONE) && restart);

    assign rd_addr   = ADDR_WIDTH'(int'(col_q) * WORDS_PER_COLUMN + int'(word_q));
    assign data_out  = data_q;
    assign extra_bit = extra_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fetch, wait for ready, pulse, then prefetch during the ack wait
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (frame_start) state_d = S_FETCH;
            S_FETCH:      state_d = S_LOAD;
            S_LOAD:       state_d = S_WAIT_READY;
            S_WAIT_READY: if (tx_finish) state_d = S_PULSE;
            S_PULSE: begin
                if (pulse_last) state_d = frame_last ? S_DONE : S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // Leave only once the next word is staged and output_module
                // has dropped tx_finish at least once since the pulse.
                if ((pf_q == PF_DONE) && (ack_seen_q || !tx_finish)) state_d = S_WAIT_READY;
            end
            S_DONE:       state_d = restart ? S_FETCH : S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // Output decode: read strobe and one-hot command selected by the current index
    always_comb begin
        busy       = (state_q != S_IDLE);
        frame_done = (state_q == S_DONE);
        rd_en      = (state_q == S_FETCH) || ((state_q == S_WAIT_ACK) && (pf_q == PF_ISSUE));
        new_image  = 1'b0;
        new_column = 1'b0;
        next_data  = 1'b0;
        if (state_q == S_PULSE) begin
            if (word_q != '0)      next_data  = 1'b1;
            else if (col_q == '0)  new_image  = 1'b1;
            else                   new_column = 1'b1;
        end
    end

    // Datapath next values: scan index, pulse timer, prefetch progress, staged and presented words
    always_comb begin
        col_d      = col_q;
        word_d     = word_q;
        pf_d       = pf_q;
        ack_seen_d = ack_seen_q;
        stage_d    = stage_q;
        data_d     = data_q;
        extra_d    = extra_q;
        pcnt_d     = (state_q == S_PULSE) ? (pcnt_q + 4'd1) : 4'd0;

        if (start_frame) begin
            col_d  = '0;
            word_d = '0;
        end

        if ((state_q == S_PULSE) && pulse_last && !frame_last) begin
            pf_d       = PF_ISSUE;
            ack_seen_d = 1'b0;
            if (word_last) begin
                word_d = '0;
                col_d  = col_q + COL_W'(1);
            end else begin
                word_d = word_q + WORD_W'(1);
            end
        end

        if (state_q == S_WAIT_ACK) begin
            if (pf_q != PF_DONE) pf_d = pf_q + 2'd1;
            if (!tx_finish)      ack_seen_d = 1'b1;
        end

        if ((state_q == S_LOAD) || ((state_q == S_WAIT_ACK) && (pf_q == PF_CAPTURE))) begin
            stage_d = rd_data;
        end

        if ((state_q == S_WAIT_READY) && tx_finish) begin
            data_d  = stage_q;
            extra_d = word_last;
        end
    end

    // Single-deep request latch for frame_start arriving while a frame runs
    always_comb begin
        pending_d = pending_q;
`ifdef MATRIX_SCAN_AUTO_REPEAT_EN
        pending_d = 1'b0;
`else
        if (state_q == S_DONE) begin
            pending_d = 1'b0;
        end else if (frame_start && (state_q != S_IDLE)) begin
            pending_d = 1'b1;
        end
`endif
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q      <= '0;
            word_q     <= '0;
            pcnt_q     <= '0;
            pf_q       <= PF_ISSUE;
            ack_seen_q <= 1'b0;
            pending_q  <= 1'b0;
            stage_q    <= '0;
            data_q     <= '0;
            extra_q    <= 1'b0;
        end else begin
            col_q      <= col_d;
            word_q     <= word_d;
            pcnt_q     <= pcnt_d;
            pf_q       <= pf_d;
            ack_seen_q <= ack_seen_d;
            pending_q  <= pending_d;
            stage_q    <= stage_d;
            data_q     <= data_d;
            extra_q    <= extra_d;
        end
    end

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Bench for matrix_scan_controller on a 2x2 frame with 5-cycle pulses.
// A small output_module / frame-buffer responder runs on the falling edge;
// every observed pulse is logged and later compared against the frame the
// specification rules predict from the frame-buffer contents.
module tb_matrix_scan_controller;

    localparam int C  = 2;
    localparam int W  = 2;
    localparam int PL = 5;
    localparam int N  = C * W;
    localparam int DW = 24;
    localparam int AW = $clog2(N);

    localparam int CMD_IMG = 1;
    localparam int CMD_COL = 2;
    localparam int CMD_NXT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          busy;
    logic          frame_done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] data_out;
    logic          extra_bit;
    logic          new_image;
    logic          new_column;
    logic          next_data;
    logic          tx_finish;

    always #5 clk = ~clk;

    matrix_scan_controller #(
        .CHANNEL_NUMBER  (3),
        .SPI_SIZE        (8),
        .COLUMNS         (C),
        .WORDS_PER_COLUMN(W),
        .PULSE_LEN       (PL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .busy       (busy),
        .frame_done (frame_done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .data_out   (data_out),
        .extra_bit  (extra_bit),
        .new_image  (new_image),
        .new_column (new_column),
        .next_data  (next_data),
        .tx_finish  (tx_finish)
    );

    typedef struct {
        int            code;
        int            len;
        logic [DW-1:0] data;
        logic          extra;
        int            addr;
    } pulse_t;

    pulse_t        pulses[$];
    int            addrs[$];
    int            fd_gaps[$];
    logic [DW-1:0] mem [N];

    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc = 0;
    int     last_end = 0;
    int     onehot_err = 0;
    int     stab_err = 0;
    int     busy_falls = 0;
    int     last_addr = -1;
    int     tx_cnt = 0;
    int     rd_pend_addr = 0;
    bit     rd_pend = 0;
    bit     in_pulse = 0;
    bit     stuck = 0;
    bit     fixed_low = 1;
    logic   busy_prev = 1'b0;
    pulse_t cur;
    string  phase = "reset";

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s_%s: observed %0h, expected %0h", phase, tag, obs, exp);
        end
    endtask

    // Frame-buffer model, output_module handshake model and pulse logger.
    initial begin
        tx_finish = 1'b1;
        rd_data   = '0;
        forever begin
            bit ended;
            int code;
            int nhot;
            @(negedge clk);
            cyc++;
            ended = 0;

            // Read data appears only in the cycle right after the strobe.
            if (rd_pend) rd_data = mem[rd_pend_addr];
            else         rd_data = DW'($urandom);
            rd_pend      = (rd_en === 1'b1);
            rd_pend_addr = int'(rd_addr);

            nhot = int'(new_image === 1'b1) + int'(new_column === 1'b1) + int'(next_data === 1'b1);
            code = (new_image === 1'b1) ? CMD_IMG : (new_column === 1'b1) ? CMD_COL :
                   (next_data === 1'b1) ? CMD_NXT : 0;
            if (nhot > 1) onehot_err++;
            if (code != 0) begin
                if (!in_pulse) begin
                    cur.code  = code;
                    cur.len   = 1;
                    cur.data  = data_out;
                    cur.extra = extra_bit;
                    cur.addr  = last_addr;
                    in_pulse  = 1;
                end else begin
                    cur.len++;
                    if (code != cur.code || data_out !== cur.data || extra_bit !== cur.extra) stab_err++;
                end
            end else if (in_pulse) begin
                pulses.push_back(cur);
                in_pulse = 0;
                ended    = 1;
                last_end = cyc;
            end
            if (frame_done === 1'b1) fd_gaps.push_back(cyc - last_end);
            if (rd_en === 1'b1) begin
                last_addr = int'(rd_addr);
                addrs.push_back(int'(rd_addr));
            end
            if (busy_prev === 1'b1 && busy === 1'b0) busy_falls++;
            busy_prev = busy;

            // output_module drops ready after each command, then recovers.
            if (stuck) begin
                tx_finish = 1'b1;
                tx_cnt    = 0;
            end else if (ended) begin
                tx_finish = 1'b0;
                tx_cnt    = fixed_low ? 20 : int'($urandom_range(1, 20));
            end else if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) tx_finish = 1'b1;
            end
        end
    end

    task automatic clear_logs();
        pulses.delete();
        addrs.delete();
        fd_gaps.delete();
        busy_falls = 0;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (fd_gaps.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("frame_done_count", fd_gaps.size(), n);
    endtask

    // Expected frame derived from the scan rules: index i = col*W + word.
    task automatic check_frame(input int pbase, input int abase);
        for (int i = 0; i < N; i++) begin
            int exp_code;
            exp_code = (i == 0) ? CMD_IMG : ((i % W) == 0) ? CMD_COL : CMD_NXT;
            if (pbase + i < pulses.size()) begin
                pulse_t p;
                p = pulses[pbase + i];
                chk($sformatf("cmd%0d", i), p.code, exp_code);
                chk($sformatf("len%0d", i), p.len, PL);
                chk($sformatf("data%0d", i), p.data, mem[i]);
                chk($sformatf("extra%0d", i), p.extra, ((i % W) == W - 1));
                chk($sformatf("prefetch%0d", i), p.addr, i);
            end
            if (abase + i < addrs.size()) chk($sformatf("rd_addr%0d", i), addrs[abase + i], i);
        end
    endtask

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        mem[0] = 24'h0F0F0F;
        mem[1] = 24'hF0F0F0;
        mem[2] = 24'hFFFFFF;
        mem[3] = 24'h000000;
        repeat (3) @(negedge clk);

        // Reset state
        chk("busy", busy, 0);
        chk("rd_en", rd_en, 0);
        chk("frame_done", frame_done, 0);
        chk("cmds", {new_image, new_column, next_data}, 0);
        chk("data_out", data_out, 0);
        chk("extra", extra_bit, 0);
        chk("rd_addr", rd_addr, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed frame with fixed rows and 20-cycle ready recovery
        phase = "frame1";
        pulse_start();
        chk("t1_rd_en", rd_en, 1);
        chk("t1_rd_addr", rd_addr, 0);
        chk("t1_busy", busy, 1);
        @(negedge clk);
        chk("t2_rd_en", rd_en, 0);
        chk("t2_img", new_image, 0);
        @(negedge clk);
        chk("t3_img", new_image, 0);
        @(negedge clk);
        chk("t4_img", new_image, 1);
        chk("t4_data", data_out, 24'h0F0F0F);
        wait_frames(1, 2000);
        repeat (3) @(negedge clk);
        chk("pulse_count", pulses.size(), N);
        chk("fetch_count", addrs.size(), N);
        check_frame(0, 0);
        if (fd_gaps.size() > 0) chk("done_gap", fd_gaps[0], 0);
        chk("busy_end", busy, 0);

        // Reset while new_column is high
        phase = "midrst";
        fixed_low = 0;
        clear_logs();
        for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
        pulse_start();
        begin
            int k = 0;
            while (new_column !== 1'b1 && k < 2000) begin
                @(negedge clk);
                k++;
            end
        end
        chk("saw_new_column", new_column, 1);
        #1 rst = 1'b1;
        #1;
        chk("busy", busy, 0);
        chk("cmds", {new_image, new_column, next_data}, 0);
        chk("rd_en", rd_en, 0);
        chk("frame_done", frame_done, 0);
        chk("data_out", data_out, 0);
        chk("extra", extra_bit, 0);
        chk("rd_addr", rd_addr, 0);
        repeat (3) @(negedge clk);
        chk("no_done", fd_gaps.size(), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_logs();
        pulse_start();
        chk("restart_rd_en", rd_en, 1);
        chk("restart_addr", rd_addr, 0);
        wait_frames(1, 2000);
        repeat (3) @(negedge clk);
        chk("pulse_count", pulses.size(), N);
        check_frame(0, 0);
        if (fd_gaps.size() > 0) chk("done_gap", fd_gaps[0], 0);

`ifdef MATRIX_SCAN_AUTO_REPEAT_EN
        // One request keeps the scan repeating
        phase = "repeat";
        clear_logs();
        for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
        pulse_start();
        wait_frames(3, 6000);
        chk("busy", busy, 1);
        chk("busy_falls", busy_falls, 0);
        for (int f = 0; f < 3; f++) begin
            check_frame(f * N, f * N);
            if (fd_gaps.size() > f) chk($sformatf("done_gap%0d", f), fd_gaps[f], 0);
        end
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
`else
        // Two extra requests during a frame yield exactly one more frame
        phase = "b2b";
        clear_logs();
        for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
        pulse_start();
        repeat (5) @(negedge clk);
        pulse_start();
        repeat (3) @(negedge clk);
        pulse_start();
        wait_frames(2, 4000);
        repeat (60) @(negedge clk);
        chk("pulse_count", pulses.size(), 2 * N);
        chk("done_count", fd_gaps.size(), 2);
        chk("busy_falls", busy_falls, 1);
        chk("busy", busy, 0);
        check_frame(0, 0);
        check_frame(N, N);
        for (int f = 0; f < 2; f++) begin
            if (fd_gaps.size() > f) chk($sformatf("done_gap%0d", f), fd_gaps[f], 0);
        end
`endif

        // tx_finish never drops after the first command
        phase = "stuck";
        stuck = 1;
        clear_logs();
        repeat (2) @(negedge clk);
        pulse_start();
        begin
            int k = 0;
            while (pulses.size() < 1 && k < 500) begin
                @(negedge clk);
                k++;
            end
        end
        repeat (100) @(negedge clk);
        chk("pulse_count", pulses.size(), 1);
        chk("cmds", {new_image, new_column, next_data}, 0);
        chk("busy", busy, 1);
        chk("prefetches", addrs.size(), 2);
        chk("no_done", fd_gaps.size(), 0);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        phase = "global";
        chk("onehot_violations", onehot_err, 0);
        chk("pulse_stability", stab_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
